at_buf_ctl: RTL and testbench
=============================

// Module: at_buf_ctl
// PURPOSE
//  Ping-pong controller for the 64-bit attribute buffers: sequences writes from the
//  attribute producer into two RAM banks and drains complete attribute sets to the
//  consumer. Drives RAM addresses, bank selects and write enable, plus the enable of
//  the 64-bit data delay latch on the RAM read port. Holds no data; control only.
// PARAMETERS
//  DEPTH  16  words per bank (power of 2, >=2)
//  AW     4   address width, log2(DEPTH)
// PORTS
//  gclk        in   1   clock; all state on rising edge
//  reset_l     in   1   reset, asynchronous, active-low
//  wr_valid    in   1   producer word valid
//  wr_last     in   1   last word of attribute set (qualified by wr_valid)
//  wr_ready    out  1   controller accepts the word this cycle
//  rd_ready    in   1   consumer accepts the presented word
//  rd_valid    out  1   latch output holds a valid word
//  rd_last     out  1   presented word is last of its set
//  ram_we      out  1   RAM write enable (= wr_valid & wr_ready)
//  ram_wbank   out  1   write bank select
//  ram_waddr   out  AW  write address
//  ram_rbank   out  1   read bank select
//  ram_raddr   out  AW  read address
//  lat_en      out  1   delay-latch enable; high when a new read word is loaded
//  bank_full   out  2   per-bank FULL/DRAINING status
// BEHAVIOUR
//  - Reset: both banks EMPTY, wb=rb=0, counts 0; all outputs 0 except wr_ready=1.
//  - Bank states: EMPTY -> FILLING (first write) -> FULL (close) -> DRAINING (first
//    read) -> EMPTY (last word handshaked). Exactly one write bank wb, one read bank rb.
//  - wr_ready = state[wb] in {EMPTY,FILLING}; combinational from registered state only.
//  - Write: ram_waddr = write count of wb; count increments per accepted word.
//  - Close: accepted word with wr_last=1, or accepted word making count==DEPTH
//    (forced close, no wr_last needed). Length latched (1..DEPTH), wb toggles next cycle.
//  - Read: when state[rb]==FULL and output stage free (!rd_valid | rd_ready), issue
//    ram_raddr, assert lat_en; rd_valid rises next cycle (1-cycle latency), aligned
//    with delay-latch output. Full throughput: one word/cycle while rd_ready=1.
//  - rd_valid/rd_last hold stable until rd_ready; no new lat_en while stalled.
//  - rd_last=1 on word index length-1; its handshake sets bank EMPTY, toggles rb.
//  - Simultaneous: write-close of one bank and drain-complete of the other in same
//    cycle are independent and both take effect. A bank freed this cycle is writable
//    from the next cycle (wr_ready reflects registered state).
//  - Both banks FULL/DRAINING -> wr_ready=0; words held by producer, never dropped.
//  - Reset asserted mid-set: immediate return to reset state; partial set discarded.
//  - Counts are AW+1 bits wide internally; no wrap within a bank.
// CONFIGURATION
//  AT_BUF_FLUSH_EN defined: extra input flush (1 bit). flush=1 synchronously forces
//   both banks EMPTY, wb=rb=0, counts 0, rd_valid=0 next cycle; wr_ready=0 during the
//   flush cycle; flush has priority over any write/read that cycle.
//  Undefined: no flush port; banks cleared only by reset_l.
// STRUCTURE
//  Package at_buf_pkg: bank-state enum (EMPTY, FILLING, FULL, DRAINING), default
//   DEPTH/AW constants.
//  Sub-module at_buf_bank: per-bank state + count + length register; instantiated x2.
//  Top holds wb/rb pointers, read output stage, RAM/latch drive.
// TESTING
//  1 Reset release, 3 words wr_last on 3rd, rd_ready=1 -> ram_waddr 0,1,2 bank0;
//    rd_valid 3 cycles, rd_last on 3rd, bank_full=00 at end.
//  2 17 words, no wr_last, DEPTH=16 -> bank0 forced close at word 16, word 17 to
//    bank1 addr 0; bank0 drains 16 words, rd_last on 16th.
//  3 Fill both banks, rd_ready=0 -> wr_ready=0, bank_full=11; raise rd_ready ->
//    wr_ready returns 1 cycle after bank0 rd_last handshake.
//  4 rd_ready toggling 1,0,0,1 mid-drain -> rd_valid/rd_last/data stable while
//    stalled; lat_en pulses only on advance; no word skipped or repeated.
//  5 reset_l low during bank1 fill of 5 words -> outputs at reset values same cycle;
//    next set starts bank0 addr 0.
//  6 (AT_BUF_FLUSH_EN) flush during drain word 2 of 8 -> rd_valid=0 next cycle,
//    bank_full=00, following write goes to bank0 addr 0.

Source files
------------

// File: rtl/at_buf_pkg.sv
// Shared types and defaults for the ping-pong attribute buffer controller.
package at_buf_pkg;

  localparam int unsigned AT_BUF_DEPTH = 16;
  localparam int unsigned AT_BUF_AW    = 4;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_e;

  // A bank "holds a set" once closed until its last word has been handshaked.
  function automatic logic holds_set(input bank_st_e s);
    return (s == FULL) || (s == DRAINING);
  endfunction

endpackage

// File: rtl/at_buf_ctl_if.sv
// Producer/consumer handshake and RAM/latch control bundle for at_buf_ctl.
interface at_buf_ctl_if
  import at_buf_pkg::*;
#(
  parameter int unsigned AW = AT_BUF_AW
);
  logic          wr_valid;
  logic          wr_last;
  logic          wr_ready;
  logic          rd_ready;
  logic          rd_valid;
  logic          rd_last;
  logic          ram_we;
  logic          ram_wbank;
  logic [AW-1:0] ram_waddr;
  logic          ram_rbank;
  logic [AW-1:0] ram_raddr;
  logic          lat_en;
  logic [1:0]    bank_full;

  modport master (
    input  wr_valid, wr_last, rd_ready,
    output wr_ready, rd_valid, rd_last, ram_we, ram_wbank, ram_waddr,
           ram_rbank, ram_raddr, lat_en, bank_full
  );

  modport slave (
    output wr_valid, wr_last, rd_ready,
    input  wr_ready, rd_valid, rd_last, ram_we, ram_wbank, ram_waddr,
           ram_rbank, ram_raddr, lat_en, bank_full
  );
endinterface

// File: rtl/at_buf_bank.sv
// One attribute RAM bank: lifecycle state, write count and latched set length.
module at_buf_bank
  import at_buf_pkg::*;
#(
  parameter int unsigned DEPTH = AT_BUF_DEPTH,
  parameter int unsigned AW    = AT_BUF_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic        wr_last,
  input  logic        rd_start,
  input  logic        rd_done,
  output bank_st_e    st,
  output logic [AW:0] cnt,
  output logic [AW:0] len,
  output logic        closing
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

  bank_st_e    st_nxt;
  logic [AW:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= EMPTY;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      EMPTY:    if (wr_en)    st_nxt = closing ? FULL : FILLING;
      FILLING:  if (closing)  st_nxt = FULL;
      FULL:     if (rd_start) st_nxt = DRAINING;
      DRAINING: if (rd_done)  st_nxt = EMPTY;
      default:                st_nxt = EMPTY;
    endcase
    if (clr) st_nxt = EMPTY;
  end

  // A full bank closes even without wr_last, so the count never wraps.
  always_comb begin
    cnt_inc = cnt + ONE;
    closing = wr_en && (wr_last || (cnt_inc == DEPTH_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      len <= '0;
    end else if (clr) begin
      cnt <= '0;
      len <= '0;
    end else if (closing) begin
      cnt <= '0;
      len <= cnt_inc;
    end else if (wr_en) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/at_buf_ctl.sv
// Ping-pong controller for two attribute RAM banks plus the read delay-latch stage.
// Optional synchronous flush input enabled by defining AT_BUF_FLUSH_EN.
module at_buf_ctl
  import at_buf_pkg::*;
#(
  parameter int unsigned DEPTH = AT_BUF_DEPTH,
  parameter int unsigned AW    = AT_BUF_AW
) (
  input  logic  gclk,
  input  logic  reset_l,
`ifdef AT_BUF_FLUSH_EN
  input  logic  flush,
`endif
  at_buf_ctl_if.master bus
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  bank_st_e    st  [2];
  logic [AW:0] cnt [2];
  logic [AW:0] len [2];
  logic [1:0]  closing;

  logic        wb, rb;
  logic [AW:0] rcnt;
  logic        rd_valid, rd_last;
  logic        flush_i;
  logic        wr_ready, we, rd_avail, issue, done;
  logic [AW:0] last_idx;
  logic [1:0]  wsel, rsel;

`ifdef AT_BUF_FLUSH_EN
  always_comb flush_i = flush;
`else
  always_comb flush_i = 1'b0;
`endif

  always_comb begin
    wr_ready = !flush_i && ((st[wb] == EMPTY) || (st[wb] == FILLING));
    we       = bus.wr_valid && wr_ready;
    // Keep issuing from a draining bank until every word of the set is out.
    rd_avail = (st[rb] == FULL) || ((st[rb] == DRAINING) && (rcnt != len[rb]));
    issue    = !flush_i && rd_avail && (!rd_valid || bus.rd_ready);
    done     = !flush_i && rd_valid && bus.rd_ready && rd_last;
    last_idx = len[rb] - ONE;
    wsel     = wb ? 2'b10 : 2'b01;
    rsel     = rb ? 2'b10 : 2'b01;
  end

  at_buf_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk(gclk), .rst_n(reset_l), .clr(flush_i),
    .wr_en(we && wsel[0]), .wr_last(bus.wr_last),
    .rd_start(issue && rsel[0]), .rd_done(done && rsel[0]),
    .st(st[0]), .cnt(cnt[0]), .len(len[0]), .closing(closing[0])
  );

  at_buf_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk(gclk), .rst_n(reset_l), .clr(flush_i),
    .wr_en(we && wsel[1]), .wr_last(bus.wr_last),
    .rd_start(issue && rsel[1]), .rd_done(done && rsel[1]),
    .st(st[1]), .cnt(cnt[1]), .len(len[1]), .closing(closing[1])
  );

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      wb       <= 1'b0;
      rb       <= 1'b0;
      rcnt     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (flush_i) begin
      wb       <= 1'b0;
      rb       <= 1'b0;
      rcnt     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (|closing) wb <= ~wb;
      if (done) begin
        rb   <= ~rb;
        rcnt <= '0;
      end else if (issue) begin
        rcnt <= rcnt + ONE;
      end
      if (issue) begin
        rd_valid <= 1'b1;
        rd_last  <= (rcnt == last_idx);
      end else if (bus.rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.wr_ready  = wr_ready;
    bus.ram_we    = we;
    bus.ram_wbank = wb;
    bus.ram_waddr = cnt[wb][AW-1:0];
    bus.ram_rbank = rb;
    bus.ram_raddr = rcnt[AW-1:0];
    bus.lat_en    = issue;
    bus.rd_valid  = rd_valid;
    bus.rd_last   = rd_last;
    bus.bank_full = {holds_set(st[1]), holds_set(st[0])};
  end

endmodule

// File: tb/tb_at_buf_ctl.sv
// Directed self-checking bench for at_buf_ctl (DEPTH=16); flush case under AT_BUF_FLUSH_EN.
module tb_at_buf_ctl;
  import at_buf_pkg::*;

  logic gclk = 1'b0;
  logic reset_l;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  int   n;

  at_buf_ctl_if #(.AW(4)) bus ();

  at_buf_ctl #(.DEPTH(16), .AW(4)) dut (
    .gclk(gclk),
    .reset_l(reset_l),
`ifdef AT_BUF_FLUSH_EN
    .flush(flush),
`endif
    .bus(bus.master)
  );

  initial forever #5 gclk = ~gclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, then settle before checking.
  task automatic cyc(input logic v, input logic l, input logic r);
    @(negedge gclk);
    bus.wr_valid = v;
    bus.wr_last  = l;
    bus.rd_ready = r;
    flush        = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge gclk);
    reset_l      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b0;
    flush        = 1'b0;
    @(negedge gclk);
    reset_l = 1'b1;
  endtask

  initial begin
    reset_l      = 1'b0;
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b0;
    cyc(0, 0, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_lat_en", bus.lat_en, 0);
    chk("rst_bank_full", bus.bank_full, 0);
    chk("rst_waddr", bus.ram_waddr, 0);
    chk("rst_wbank", bus.ram_wbank, 0);
    chk("rst_rbank", bus.ram_rbank, 0);

    // 1: three-word set, consumer always ready
    do_reset();
    cyc(1, 0, 1); chk("t1_we0", bus.ram_we, 1); chk("t1_waddr0", bus.ram_waddr, 0);
    chk("t1_wbank0", bus.ram_wbank, 0);
    cyc(1, 0, 1); chk("t1_waddr1", bus.ram_waddr, 1);
    cyc(1, 1, 1); chk("t1_waddr2", bus.ram_waddr, 2); chk("t1_we2", bus.ram_we, 1);
    cyc(0, 0, 1); chk("t1_wbank_sw", bus.ram_wbank, 1); chk("t1_full", bus.bank_full, 2'b01);
    chk("t1_lat0", bus.lat_en, 1); chk("t1_raddr0", bus.ram_raddr, 0);
    chk("t1_rv0", bus.rd_valid, 0); chk("t1_wr_ready", bus.wr_ready, 1);
    cyc(0, 0, 1); chk("t1_rv1", bus.rd_valid, 1); chk("t1_rl1", bus.rd_last, 0);
    chk("t1_raddr1", bus.ram_raddr, 1); chk("t1_lat1", bus.lat_en, 1);
    cyc(0, 0, 1); chk("t1_rv2", bus.rd_valid, 1); chk("t1_rl2", bus.rd_last, 0);
    chk("t1_raddr2", bus.ram_raddr, 2);
    cyc(0, 0, 1); chk("t1_rv3", bus.rd_valid, 1); chk("t1_rl3", bus.rd_last, 1);
    chk("t1_lat3", bus.lat_en, 0);
    cyc(0, 0, 1); chk("t1_rv_end", bus.rd_valid, 0); chk("t1_full_end", bus.bank_full, 0);
    chk("t1_rbank_end", bus.ram_rbank, 1);

    // 2: 17 words without wr_last -> forced close at 16
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 1);
      chk("t2_we", bus.ram_we, 1);
      if (i < 16) begin
        chk("t2_wbank", bus.ram_wbank, 0);
        chk("t2_waddr", bus.ram_waddr, i);
      end else begin
        chk("t2_wbank17", bus.ram_wbank, 1);
        chk("t2_waddr17", bus.ram_waddr, 0);
        chk("t2_lat_first", bus.lat_en, 1);
      end
    end
    n = 0;
    for (int k = 0; k < 40 && n < 16; k++) begin
      cyc(0, 0, 1);
      if (bus.rd_valid === 1'b1) begin
        n++;
        chk("t2_rd_last", bus.rd_last, (n == 16) ? 1 : 0);
      end
    end
    chk("t2_words", n, 16);
    cyc(0, 0, 1); chk("t2_rv_end", bus.rd_valid, 0); chk("t2_full_end", bus.bank_full, 0);
    chk("t2_lat_end", bus.lat_en, 0); chk("t2_waddr_b1", bus.ram_waddr, 1);

    // 3: both banks full while consumer stalls
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 3, 0); chk("t3_wbank_a", bus.ram_wbank, 0); chk("t3_waddr_a", bus.ram_waddr, i);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 3, 0); chk("t3_wbank_b", bus.ram_wbank, 1); chk("t3_waddr_b", bus.ram_waddr, i);
      if (i == 0) chk("t3_lat_first", bus.lat_en, 1);
    end
    cyc(1, 0, 0); chk("t3_wr_ready0", bus.wr_ready, 0); chk("t3_we0", bus.ram_we, 0);
    chk("t3_full11", bus.bank_full, 2'b11); chk("t3_lat_stall", bus.lat_en, 0);
    chk("t3_rv_stall", bus.rd_valid, 1);
    cyc(1, 0, 0); chk("t3_wr_ready0b", bus.wr_ready, 0);
    cyc(1, 0, 1); chk("t3_raddr1", bus.ram_raddr, 1); chk("t3_lat1", bus.lat_en, 1);
    chk("t3_rl_a", bus.rd_last, 0);
    cyc(1, 0, 1); chk("t3_raddr2", bus.ram_raddr, 2);
    cyc(1, 0, 1); chk("t3_raddr3", bus.ram_raddr, 3); chk("t3_lat3", bus.lat_en, 1);
    cyc(1, 0, 1); chk("t3_rl_last", bus.rd_last, 1); chk("t3_wr_ready_hs", bus.wr_ready, 0);
    cyc(1, 0, 1); chk("t3_wr_ready1", bus.wr_ready, 1); chk("t3_we1", bus.ram_we, 1);
    chk("t3_wbank", bus.ram_wbank, 0); chk("t3_waddr", bus.ram_waddr, 0);
    chk("t3_full10", bus.bank_full, 2'b10); chk("t3_rbank1", bus.ram_rbank, 1);
    chk("t3_lat_b", bus.lat_en, 1); chk("t3_rv_gap", bus.rd_valid, 0);

    // 4: consumer backpressure 1,0,0,1 mid-drain
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, i == 3, 1);
    cyc(0, 0, 1); chk("t4_lat0", bus.lat_en, 1); chk("t4_raddr0", bus.ram_raddr, 0);
    cyc(0, 0, 1); chk("t4_rv1", bus.rd_valid, 1); chk("t4_lat1", bus.lat_en, 1);
    chk("t4_raddr1", bus.ram_raddr, 1);
    cyc(0, 0, 0); chk("t4_rv_s1", bus.rd_valid, 1); chk("t4_rl_s1", bus.rd_last, 0);
    chk("t4_lat_s1", bus.lat_en, 0);
    cyc(0, 0, 0); chk("t4_rv_s2", bus.rd_valid, 1); chk("t4_lat_s2", bus.lat_en, 0);
    chk("t4_raddr_s2", bus.ram_raddr, 2);
    cyc(0, 0, 1); chk("t4_lat_r", bus.lat_en, 1); chk("t4_raddr_r", bus.ram_raddr, 2);
    cyc(0, 0, 1); chk("t4_raddr3", bus.ram_raddr, 3); chk("t4_rl2", bus.rd_last, 0);
    cyc(0, 0, 1); chk("t4_rl3", bus.rd_last, 1); chk("t4_lat_end", bus.lat_en, 0);
    cyc(0, 0, 1); chk("t4_rv_end", bus.rd_valid, 0); chk("t4_full_end", bus.bank_full, 0);

    // 5: reset mid-fill of bank1
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0); chk("t5_wbank", bus.ram_wbank, 1); chk("t5_waddr", bus.ram_waddr, i);
    end
    @(negedge gclk);
    reset_l      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    #1;
    chk("t5_wr_ready", bus.wr_ready, 1); chk("t5_rv", bus.rd_valid, 0);
    chk("t5_full", bus.bank_full, 0); chk("t5_wbank_r", bus.ram_wbank, 0);
    chk("t5_waddr_r", bus.ram_waddr, 0); chk("t5_lat", bus.lat_en, 0);
    chk("t5_rbank", bus.ram_rbank, 0);
    @(negedge gclk);
    reset_l = 1'b1;
    cyc(1, 1, 0); chk("t5_new_wbank", bus.ram_wbank, 0); chk("t5_new_waddr", bus.ram_waddr, 0);
    chk("t5_new_we", bus.ram_we, 1);
    cyc(0, 0, 0); chk("t5_new_full", bus.bank_full, 2'b01);

`ifdef AT_BUF_FLUSH_EN
    // 6: flush while second word of an 8-word set is presented
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, i == 7, 1);
    cyc(0, 0, 1); chk("t6_lat0", bus.lat_en, 1);
    cyc(0, 0, 1); chk("t6_rv1", bus.rd_valid, 1);
    @(negedge gclk);
    flush = 1'b1;
    #1;
    chk("t6_wr_ready_fl", bus.wr_ready, 0); chk("t6_lat_fl", bus.lat_en, 0);
    cyc(1, 0, 1); chk("t6_rv", bus.rd_valid, 0); chk("t6_full", bus.bank_full, 0);
    chk("t6_wbank", bus.ram_wbank, 0); chk("t6_waddr", bus.ram_waddr, 0);
    chk("t6_we", bus.ram_we, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
